timer_bus_arbiter: RTL and testbench

- Two-master to one-slave AXI4-Lite arbiter that shares the memory-mapped machine timer between two requesters, e.g. core data port and debug/DMA port.
- Round-robin grant with one outstanding transaction.
- Request is captured into registers at grant, then replayed to the timer slave; the slave response is buffered and returned to the granted master.
- A watchdog converts a hung slave into an SLVERR response.

---
 rtl/timer_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_timer_bus_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/timer_bus_arbiter.sv
// timer_bus_arbiter: round-robin 2-master AXI4-Lite arbiter in front of the machine timer; one outstanding transaction, buffered response, watchdog SLVERR
module timer_bus_arbiter #(
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_awvalid,
  input  logic                    m0_wvalid,
  input  logic                    m0_arvalid,
  input  logic                    m0_bready,
  input  logic                    m0_rready,
  input  logic [AddressWidth-1:0] m0_awaddr,
  input  logic [AddressWidth-1:0] m0_araddr,
  input  logic [DataWidth-1:0]    m0_wdata,
  input  logic [3:0]              m0_be,
  output logic                    m0_awready,
  output logic                    m0_wready,
  output logic                    m0_arready,
  output logic                    m0_bvalid,
  output logic                    m0_rvalid,
  output logic [1:0]              m0_bresp,
  output logic [1:0]              m0_rresp,
  output logic [DataWidth-1:0]    m0_rdata,
  input  logic                    m1_awvalid,
  input  logic                    m1_wvalid,
  input  logic                    m1_arvalid,
  input  logic                    m1_bready,
  input  logic                    m1_rready,
  input  logic [AddressWidth-1:0] m1_awaddr,
  input  logic [AddressWidth-1:0] m1_araddr,
  input  logic [DataWidth-1:0]    m1_wdata,
  input  logic [3:0]              m1_be,
  output logic                    m1_awready,
  output logic                    m1_wready,
  output logic                    m1_arready,
  output logic                    m1_bvalid,
  output logic                    m1_rvalid,
  output logic [1:0]              m1_bresp,
  output logic [1:0]              m1_rresp,
  output logic [DataWidth-1:0]    m1_rdata,
  output logic                    s_awvalid,
  output logic                    s_wvalid,
  output logic                    s_arvalid,
  output logic                    s_bready,
  output logic                    s_rready,
  output logic [AddressWidth-1:0] s_awaddr,
  output logic [AddressWidth-1:0] s_araddr,
  output logic [DataWidth-1:0]    s_wdata,
  output logic [3:0]              s_be,
  output logic [2:0]              s_awprot,
  output logic [2:0]              s_arprot,
  input  logic                    s_awready,
  input  logic                    s_wready,
  input  logic                    s_arready,
  input  logic                    s_bvalid,
  input  logic                    s_rvalid,
  input  logic [1:0]              s_bresp,
  input  logic [1:0]              s_rresp,
  input  logic [DataWidth-1:0]    s_rdata,
  output logic                    busy_o
);
  typedef enum logic [2:0] {IDLE, REQ_RD, REQ_WR, WAIT_RD, WAIT_WR, RESP} state_e;
  state_e                  state_q, state_d;
  logic                    rr_ptr_q, rr_ptr_d, gid_q, gid_d, rd_q, rd_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]              be_q, be_d;
  logic [1:0]              resp_q, resp_d;
  logic                    rd0, rd1, req0, req1, win, win_rd, grant, tmo, resp_hs;
  always_comb begin
    rd0        = m0_arvalid;
    rd1        = m1_arvalid;
    req0       = rd0 | (m0_awvalid & m0_wvalid);
    req1       = rd1 | (m1_awvalid & m1_wvalid);
    win        = (req0 & req1) ? ~rr_ptr_q : req1;
    win_rd     = win ? rd1 : rd0;
    grant      = (state_q == IDLE) & (req0 | req1);
    tmo        = cnt_q == 16'(TimeoutCycles - 1);
    m0_arready = grant & ~win & win_rd;
    m1_arready = grant & win & win_rd;
    m0_awready = grant & ~win & ~win_rd;
    m1_awready = grant & win & ~win_rd;
    m0_wready  = m0_awready;
    m1_wready  = m1_awready;
    // Valids are dropped on the watchdog cycle so the slave never sees a handshake we are abandoning.
    s_arvalid  = (state_q == REQ_RD) & ~tmo;
    s_awvalid  = (state_q == REQ_WR) & ~aw_done_q & ~tmo;
    s_wvalid   = (state_q == REQ_WR) & ~w_done_q & ~tmo;
    // IDLE keeps both readies high so late responses from a timed-out transaction are drained.
    s_rready   = (state_q == IDLE) | (state_q == WAIT_RD);
    s_bready   = (state_q == IDLE) | (state_q == WAIT_WR);
    s_awaddr   = addr_q;
    s_araddr   = addr_q;
    s_wdata    = wdata_q;
    s_be       = be_q;
    s_awprot   = 3'b000;
    s_arprot   = 3'b000;
    m0_rvalid  = (state_q == RESP) & ~gid_q & rd_q;
    m1_rvalid  = (state_q == RESP) & gid_q & rd_q;
    m0_bvalid  = (state_q == RESP) & ~gid_q & ~rd_q;
    m1_bvalid  = (state_q == RESP) & gid_q & ~rd_q;
    m0_rdata   = m0_rvalid ? rdata_q : '0;
    m1_rdata   = m1_rvalid ? rdata_q : '0;
    m0_rresp   = m0_rvalid ? resp_q : 2'b00;
    m1_rresp   = m1_rvalid ? resp_q : 2'b00;
    m0_bresp   = m0_bvalid ? resp_q : 2'b00;
    m1_bresp   = m1_bvalid ? resp_q : 2'b00;
    resp_hs    = (m0_rvalid & m0_rready) | (m1_rvalid & m1_rready) | (m0_bvalid & m0_bready) | (m1_bvalid & m1_bready);
    busy_o     = state_q != IDLE;
  end
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gid_d     = gid_q;
    rd_d      = rd_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    case (state_q)
      IDLE: if (grant) begin
        gid_d     = win;
        rd_d      = win_rd;
        cnt_d     = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        addr_d    = win_rd ? (win ? m1_araddr : m0_araddr) : (win ? m1_awaddr : m0_awaddr);
        wdata_d   = win_rd ? wdata_q : (win ? m1_wdata : m0_wdata);
        be_d      = win_rd ? be_q : (win ? m1_be : m0_be);
        state_d   = win_rd ? REQ_RD : REQ_WR;
      end
      REQ_RD, REQ_WR, WAIT_RD, WAIT_WR: begin
        cnt_d     = cnt_q + 16'd1;
        aw_done_d = aw_done_q | (s_awvalid & s_awready);
        w_done_d  = w_done_q | (s_wvalid & s_wready);
        if (state_q == REQ_RD && s_arvalid && s_arready) state_d = WAIT_RD;
        else if (state_q == REQ_WR && aw_done_d && w_done_d) state_d = WAIT_WR;
        else if (state_q == WAIT_RD && s_rvalid) begin
          rdata_d = s_rdata;
          resp_d  = s_rresp;
          state_d = RESP;
        end else if (state_q == WAIT_WR && s_bvalid) begin
          resp_d  = s_bresp;
          state_d = RESP;
        end else if (tmo) begin
          rdata_d = '0;
          resp_d  = 2'b10;
          state_d = RESP;
        end
      end
      RESP: if (resp_hs) begin
        rr_ptr_d = gid_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      gid_q     <= 1'b0;
      rd_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gid_q     <= gid_d;
      rd_q      <= rd_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end
endmodule

// File: tb/tb_timer_bus_arbiter.sv
// tb_timer_bus_arbiter: directed self-checking bench for timer_bus_arbiter
module tb_timer_bus_arbiter;
  logic clk_i = 0, rst_i = 1;
  logic m0_awvalid = 0, m0_wvalid = 0, m0_arvalid = 0, m0_bready = 0, m0_rready = 0;
  logic [31:0] m0_awaddr = 0, m0_araddr = 0, m0_wdata = 0;
  logic [3:0] m0_be = 0;
  logic m0_awready, m0_wready, m0_arready, m0_bvalid, m0_rvalid;
  logic [1:0] m0_bresp, m0_rresp;
  logic [31:0] m0_rdata;
  logic m1_awvalid = 0, m1_wvalid = 0, m1_arvalid = 0, m1_bready = 0, m1_rready = 0;
  logic [31:0] m1_awaddr = 0, m1_araddr = 0, m1_wdata = 0;
  logic [3:0] m1_be = 0;
  logic m1_awready, m1_wready, m1_arready, m1_bvalid, m1_rvalid;
  logic [1:0] m1_bresp, m1_rresp;
  logic [31:0] m1_rdata;
  logic s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
  logic [31:0] s_awaddr, s_araddr, s_wdata;
  logic [3:0] s_be;
  logic [2:0] s_awprot, s_arprot;
  logic s_awready = 0, s_wready = 0, s_arready = 0, s_bvalid = 0, s_rvalid = 0;
  logic [1:0] s_bresp = 0, s_rresp = 0;
  logic [31:0] s_rdata = 0;
  logic busy_o;
  int vectors = 0, errors = 0, n;
  timer_bus_arbiter #(.AddressWidth(32), .DataWidth(32), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_awvalid(m0_awvalid), .m0_wvalid(m0_wvalid), .m0_arvalid(m0_arvalid), .m0_bready(m0_bready), .m0_rready(m0_rready),
    .m0_awaddr(m0_awaddr), .m0_araddr(m0_araddr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_awready(m0_awready), .m0_wready(m0_wready), .m0_arready(m0_arready), .m0_bvalid(m0_bvalid), .m0_rvalid(m0_rvalid),
    .m0_bresp(m0_bresp), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
    .m1_awvalid(m1_awvalid), .m1_wvalid(m1_wvalid), .m1_arvalid(m1_arvalid), .m1_bready(m1_bready), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_araddr(m1_araddr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_awready(m1_awready), .m1_wready(m1_wready), .m1_arready(m1_arready), .m1_bvalid(m1_bvalid), .m1_rvalid(m1_rvalid),
    .m1_bresp(m1_bresp), .m1_rresp(m1_rresp), .m1_rdata(m1_rdata),
    .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_arvalid(s_arvalid), .s_bready(s_bready), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_araddr(s_araddr), .s_wdata(s_wdata), .s_be(s_be), .s_awprot(s_awprot), .s_arprot(s_arprot),
    .s_awready(s_awready), .s_wready(s_wready), .s_arready(s_arready), .s_bvalid(s_bvalid), .s_rvalid(s_rvalid),
    .s_bresp(s_bresp), .s_rresp(s_rresp), .s_rdata(s_rdata), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_drain", {s_bready, s_rready}, 2'b11);
    chk("rst_svalid", {s_awvalid, s_wvalid, s_arvalid}, 0);
    chk("rst_mout", {m0_rvalid, m0_bvalid, m0_rdata, m1_rvalid, m1_bvalid, m1_rdata}, 0);
    chk("rst_prot", {s_awprot, s_arprot}, 0);
    rst_i = 0;
    s_arready = 1; s_awready = 1; s_wready = 1; s_rvalid = 1; s_rdata = 32'h1234_5678;
    tick();
    m0_arvalid = 1; m0_araddr = 32'h4; m0_rready = 1; #1;
    chk("t1_arready", {m0_arready, m1_arready, m0_awready}, 3'b100);
    tick();
    m0_arvalid = 0; #1;
    chk("t1_sar", {s_arvalid, s_araddr}, {1'b1, 32'h4});
    chk("t1_busy", busy_o, 1);
    tick();
    chk("t1_rready", s_rready, 1);
    chk("t1_early", m0_rvalid, 0);
    tick();
    chk("t1_rvalid", {m0_rvalid, m0_rresp, m0_rdata}, {1'b1, 2'b00, 32'h1234_5678});
    chk("t1_m1", {m1_rvalid, m1_bvalid, m1_rdata, m1_rresp, m1_bresp, m1_arready, m1_awready}, 0);
    tick();
    chk("t1_idle", {busy_o, m0_rvalid}, 0);
    m0_arvalid = 1; m1_arvalid = 1; m0_araddr = 32'h10; m1_araddr = 32'h20; m1_rready = 1; #1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant", {m1_arready, m0_arready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      chk("t2_addr", s_araddr, (k % 2 == 0) ? 32'h20 : 32'h10);
      tick();
      tick();
      chk("t2_rvalid", {m1_rvalid, m0_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0; s_wready = 0;
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h8; m1_wdata = 32'hDEAD_BEEF; m1_be = 4'b0011; m1_bready = 1; #1;
    chk("t3_grant", {m1_awready, m1_wready, m0_awready}, 3'b110);
    tick();
    m1_awvalid = 0; m1_wvalid = 0; #1;
    chk("t3_sreq", {s_awvalid, s_wvalid, s_awaddr, s_wdata, s_be}, {2'b11, 32'h8, 32'hDEAD_BEEF, 4'b0011});
    tick();
    chk("t3_awdrop", {s_awvalid, s_wvalid}, 2'b01);
    tick();
    s_wready = 1; #1;
    chk("t3_whold", {s_awvalid, s_wvalid}, 2'b01);
    tick();
    s_bvalid = 1; s_bresp = 2'b00; #1;
    chk("t3_bready", {s_bready, s_awvalid, s_wvalid}, 3'b100);
    tick();
    s_bvalid = 0; #1;
    chk("t3_bvalid", {m1_bvalid, m1_bresp, m0_bvalid}, {1'b1, 2'b00, 1'b0});
    tick();
    chk("t3_single", {m1_bvalid, busy_o}, 0);
    s_arready = 0; s_rvalid = 0; s_rdata = 32'h5555_AAAA;
    m0_arvalid = 1; m0_araddr = 32'hC; m0_rready = 0; #1;
    chk("t4_grant", m0_arready, 1);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      m0_arvalid = 0; #1;
      if (c == 1) chk("t4_sarv", s_arvalid, 1);
      if (m0_rvalid) begin
        n = c;
        break;
      end
    end
    chk("t4_tmo_cycle", n, 9);
    chk("t4_err", {m0_rvalid, m0_rresp, m0_rdata, s_arvalid}, {1'b1, 2'b10, 32'h0, 1'b0});
    tick();
    chk("t4_hold", {busy_o, m0_rvalid}, 2'b11);
    m0_rready = 1;
    tick();
    chk("t4_idle", busy_o, 0);
    s_rvalid = 1; #1;
    chk("t4_drain", {s_rready, m0_rvalid, m1_rvalid}, 3'b100);
    tick();
    chk("t4_nolate", {m0_rvalid, m1_rvalid, busy_o}, 0);
    s_arready = 1; s_rdata = 32'hA5A5_0001; s_bvalid = 1; s_bresp = 2'b00;
    m0_rready = 0; m0_arvalid = 1; m0_araddr = 32'h30;
    m0_awvalid = 1; m0_wvalid = 1; m0_awaddr = 32'h34; m0_wdata = 32'h0BAD_F00D; m0_be = 4'hF; m0_bready = 1; #1;
    chk("t5_rdfirst", {m0_arready, m0_awready}, 2'b10);
    tick();
    m0_arvalid = 0; #1;
    chk("t5_wrwait", m0_awready, 0);
    tick();
    tick();
    s_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      chk("t5_stable", {m0_rvalid, m0_rdata}, {1'b1, 32'hA5A5_0001});
      tick();
    end
    m0_rready = 1; #1;
    chk("t5_accept", {m0_rvalid, m0_rdata}, {1'b1, 32'hA5A5_0001});
    tick();
    chk("t5_wrgrant", {m0_awready, m0_wready, m0_arready}, 3'b110);
    tick();
    m0_awvalid = 0; m0_wvalid = 0; #1;
    chk("t5_swr", {s_awvalid, s_awaddr, s_wdata}, {1'b1, 32'h34, 32'h0BAD_F00D});
    tick();
    tick();
    chk("t5_bvalid", {m0_bvalid, m0_bresp}, {1'b1, 2'b00});
    tick();
    s_bvalid = 0;
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h40; #1;
    chk("t6_grant", m1_awready, 1);
    tick();
    m1_awvalid = 0; m1_wvalid = 0;
    tick();
    chk("t6_wait", {busy_o, s_bready}, 2'b11);
    rst_i = 1;
    tick();
    rst_i = 0; #1;
    chk("t6_rst", {busy_o, m0_bvalid, m1_bvalid}, 0);
    s_bvalid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_nob", {m0_bvalid, m1_bvalid, busy_o}, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
